// File: rtl/cbus_arbiter.sv
// N-to-1 CBus arbiter; round-robin, or fixed lowest-index priority when CBUS_ARB_FIXED_PRIO_EN is defined.
// Latency: 1 cycle from request valid to oreq.valid; grant is held until ready&&last or master abort.
// Backpressure: purely combinational passthrough of oresp to the owner; losers see ready=0.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_MASTERS],
    output cbus_resp_t iresps [NUM_MASTERS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] sel, sel_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic             any_valid;

    // Scan from rr_ptr upwards with wrap; with rr_ptr tied to 0 this is lowest-index priority.
    always_comb begin
        int idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!any_valid && ireqs[idx].valid) begin
                winner    = IDX_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

`ifndef CBUS_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_nxt;
`endif

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
`ifndef CBUS_ARB_FIXED_PRIO_EN
        rr_nxt    = rr_ptr;
`endif
        oreq      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) iresps[i] = '0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    sel_nxt   = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                oreq         = ireqs[sel];
                iresps[sel]  = oresp;
                // A dropped valid is an abort and releases the bus just like a final beat.
                if (!ireqs[sel].valid || (oresp.ready && oresp.last)) begin
                    state_nxt = IDLE;
`ifndef CBUS_ARB_FIXED_PRIO_EN
                    rr_nxt    = (sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

`ifdef CBUS_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (reset) rr_ptr <= '0;
        else       rr_ptr <= rr_nxt;
    end
`endif

`ifndef SYNTHESIS
    logic [NUM_MASTERS-1:0] ready_vec;
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < NUM_MASTERS; i++) ready_vec[i] = iresps[i].ready;
    end

    a_valid_busy: assert property (@(posedge clk) disable iff (reset) oreq.valid |-> state == BUSY);
    a_one_ready:  assert property (@(posedge clk) disable iff (reset) $onehot0(ready_vec));
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: a 2-master instance for most scenarios and a 3-master instance for wrap.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    cbus_req_t  ireqs   [2];
    cbus_resp_t iresps  [2];
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    cbus_req_t  ireqs3  [3];
    cbus_resp_t iresps3 [3];
    cbus_req_t  oreq3;
    cbus_resp_t oresp3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cbus_arbiter #(.NUM_MASTERS(2)) dut (
        .clk(clk), .reset(reset), .ireqs(ireqs), .iresps(iresps), .oreq(oreq), .oresp(oresp)
    );

    cbus_arbiter #(.NUM_MASTERS(3)) dut3 (
        .clk(clk), .reset(reset), .ireqs(ireqs3), .iresps(iresps3), .oreq(oreq3), .oresp(oresp3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic cbus_req_t mk_req(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        cbus_req_t r;
        r        = '0;
        r.valid  = 1'b1;
        r.size   = 3'd2;
        r.addr   = addr;
        r.strobe = 4'hf;
        r.len    = len;
        r.burst  = burst;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic ready, input logic last, input logic [31:0] data);
        cbus_resp_t r;
        r.ready = ready;
        r.last  = last;
        r.data  = data;
        return r;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < 2; i++) ireqs[i] = '0;
        for (int i = 0; i < 3; i++) ireqs3[i] = '0;
        oresp  = '0;
        oresp3 = '0;
    endtask

    initial begin
        clear_all();
        reset = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_oreq",    64'(oreq), 64'd0);
        chk("rst_iresp0",  64'(iresps[0]), 64'd0);
        chk("rst_iresp1",  64'(iresps[1]), 64'd0);
        chk("rst_state",   64'(dut.state), 64'd0);
        chk("rst_sel",     64'(dut.sel), 64'd0);
        chk("rst_rr",      64'(dut.rr_ptr), 64'd0);
        chk("rst3_oreq",   64'(oreq3), 64'd0);
        reset = 1'b0;

        // Single FIXED read by master 1
        ireqs[1] = mk_req(32'h8000_0000, 8'd0, 2'd0);
        settle();
        chk("t1_idle_vld", 64'(oreq.valid), 64'd0);
        tick();
        oresp = mk_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
        settle();
        chk("t1_oreq_vld",  64'(oreq.valid), 64'd1);
        chk("t1_oreq_addr", 64'(oreq.addr), 64'h8000_0000);
        chk("t1_r1_ready",  64'(iresps[1].ready), 64'd1);
        chk("t1_r1_last",   64'(iresps[1].last), 64'd1);
        chk("t1_r1_data",   64'(iresps[1].data), 64'hDEAD_BEEF);
        chk("t1_r0_ready",  64'(iresps[0].ready), 64'd0);
        tick();
        clear_all();
        settle();
        chk("t1_back_idle", 64'(dut.state), 64'd0);
        chk("t1_rr",        64'(dut.rr_ptr), 64'd0);
        chk("t1_idle_oreq", 64'(oreq.valid), 64'd0);

        // Two masters requesting continuously alternate
        ireqs[0] = mk_req(32'h8000_0100, 8'd0, 2'd0);
        ireqs[1] = mk_req(32'h8000_0200, 8'd0, 2'd0);
        oresp    = mk_resp(1'b1, 1'b1, 32'h1234_5678);
        for (int k = 0; k < 4; k++) begin
            tick();
`ifdef CBUS_ARB_FIXED_PRIO_EN
            chk("t2_sel", 64'(dut.sel), 64'd0);
`else
            chk("t2_sel", 64'(dut.sel), 64'(k % 2));
`endif
            chk("t2_busy_vld", 64'(oreq.valid), 64'd1);
            chk("t2_onehot",   64'(iresps[0].ready ^ iresps[1].ready), 64'd1);
            tick();
            chk("t2_gap_vld",  64'(oreq.valid), 64'd0);
        end
        clear_all();
        tick();

        // INCR len=3 burst from master 0, master 1 raises valid on beat 1
        ireqs[0] = mk_req(32'h8000_1000, 8'd3, 2'd1);
        tick();
        oresp = mk_resp(1'b1, 1'b0, 32'h0000_0000);
        settle();
        chk("t3_b0_sel",   64'(dut.sel), 64'd0);
        chk("t3_b0_addr",  64'(oreq.addr), 64'h8000_1000);
        chk("t3_b0_rdy0",  64'(iresps[0].ready), 64'd1);
        tick();
        ireqs[1] = mk_req(32'h8000_2000, 8'd0, 2'd0);
        oresp    = mk_resp(1'b1, 1'b0, 32'h0000_0001);
        settle();
        chk("t3_b1_sel",   64'(dut.sel), 64'd0);
        chk("t3_b1_rdy1",  64'(iresps[1].ready), 64'd0);
        chk("t3_b1_addr",  64'(oreq.addr), 64'h8000_1000);
        tick();
        oresp = mk_resp(1'b1, 1'b0, 32'h0000_0002);
        settle();
        chk("t3_b2_sel",   64'(dut.sel), 64'd0);
        chk("t3_b2_rdy1",  64'(iresps[1].ready), 64'd0);
        tick();
        oresp = mk_resp(1'b1, 1'b1, 32'h0000_0003);
        settle();
        chk("t3_b3_sel",   64'(dut.sel), 64'd0);
        chk("t3_b3_last0", 64'(iresps[0].last), 64'd1);
        chk("t3_b3_rdy1",  64'(iresps[1].ready), 64'd0);
        tick();
        ireqs[0] = '0;
        oresp    = '0;
        settle();
        chk("t3_gap_vld",  64'(oreq.valid), 64'd0);
        chk("t3_gap_rdy1", 64'(iresps[1].ready), 64'd0);
        tick();
        oresp = mk_resp(1'b1, 1'b1, 32'hCAFE_0001);
        settle();
        chk("t3_m1_sel",   64'(dut.sel), 64'd1);
        chk("t3_m1_addr",  64'(oreq.addr), 64'h8000_2000);
        chk("t3_m1_data",  64'(iresps[1].data), 64'hCAFE_0001);
        tick();
        clear_all();
        settle();
        chk("t3_rr", 64'(dut.rr_ptr), 64'd0);

        // Master 0 single transfer (advances rr_ptr), then a len=7 burst reset on beat 2
        ireqs[0] = mk_req(32'h8000_3000, 8'd0, 2'd0);
        oresp    = mk_resp(1'b1, 1'b1, 32'h0);
        tick();
        tick();
        oresp    = '0;
`ifndef CBUS_ARB_FIXED_PRIO_EN
        chk("t4_rr_pre", 64'(dut.rr_ptr), 64'd1);
`endif
        ireqs[0] = mk_req(32'h8000_4000, 8'd7, 2'd1);
        tick();
        oresp = mk_resp(1'b1, 1'b0, 32'h0);
        chk("t4_b0_sel", 64'(dut.sel), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        settle();
        chk("t4_b2_vld", 64'(oreq.valid), 64'd1);
        tick();
        reset = 1'b0;
        settle();
        chk("t4_rst_vld",   64'(oreq.valid), 64'd0);
        chk("t4_rst_r0",    64'(iresps[0]), 64'd0);
        chk("t4_rst_r1",    64'(iresps[1]), 64'd0);
        chk("t4_rst_rr",    64'(dut.rr_ptr), 64'd0);
        chk("t4_rst_state", 64'(dut.state), 64'd0);
        ireqs[1] = mk_req(32'h8000_5000, 8'd0, 2'd0);
        oresp    = mk_resp(1'b1, 1'b1, 32'h0);
        tick();
        chk("t4_post_sel", 64'(dut.sel), 64'd0);
        tick();
        clear_all();
        settle();
`ifndef CBUS_ARB_FIXED_PRIO_EN
        chk("t4_post_rr", 64'(dut.rr_ptr), 64'd1);
`endif

        // Master 0 aborts on beat 1 of a len=3 burst; master 1 pending
        ireqs[0] = mk_req(32'h8000_6000, 8'd3, 2'd1);
        tick();
        oresp = mk_resp(1'b1, 1'b0, 32'h0);
        settle();
        chk("t5_b0_sel", 64'(dut.sel), 64'd0);
        tick();
        ireqs[0] = '0;
        ireqs[1] = mk_req(32'h8000_7000, 8'd0, 2'd0);
        settle();
        chk("t5_abort_vld", 64'(oreq.valid), 64'd0);
        tick();
        oresp = '0;
        settle();
        chk("t5_idle_state", 64'(dut.state), 64'd0);
        chk("t5_idle_vld",   64'(oreq.valid), 64'd0);
`ifndef CBUS_ARB_FIXED_PRIO_EN
        chk("t5_idle_rr",    64'(dut.rr_ptr), 64'd1);
`endif
        tick();
        chk("t5_m1_sel",  64'(dut.sel), 64'd1);
        chk("t5_m1_addr", 64'(oreq.addr), 64'h8000_7000);
        clear_all();
        tick();

        // 3-master instance: only master 2 requests, rr_ptr wraps to 0
        ireqs3[2] = mk_req(32'h8000_8000, 8'd0, 2'd0);
        oresp3    = mk_resp(1'b1, 1'b1, 32'hA5A5_0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_sel",    64'(dut3.sel), 64'd2);
            chk("t6_rdy2",   64'(iresps3[2].ready), 64'd1);
            chk("t6_rdy0",   64'(iresps3[0].ready), 64'd0);
            chk("t6_addr",   64'(oreq3.addr), 64'h8000_8000);
            tick();
            chk("t6_rr",     64'(dut3.rr_ptr), 64'd0);
            chk("t6_gapvld", 64'(oreq3.valid), 64'd0);
        end
        clear_all();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cbus_arbiter.md
Name: cbus_arbiter

Overview:
- N-to-1 arbiter that merges several CBus masters (icache, dcache, uncached path) onto the single CBus port of the memory-side bridge (CBus-to-SRAM).
- Grants one master at a time and holds the grant for a whole transaction, including every beat of an INCR burst, until the downstream side signals the final beat.
- Round-robin fairness by default.
- Purely a routing/ownership stage: no data buffering, no address modification.

Parameters:
NUM_MASTERS, 2, number of upstream CBus masters (>=2, <=8)
IDX_W, $clog2(NUM_MASTERS), width of internal grant index

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
ireqs  input  NUM_MASTERS x cbus_req_t  upstream requests {valid, is_write, size, addr, strobe, data, len, burst}
iresps  output  NUM_MASTERS x cbus_resp_t  upstream responses {ready, last, data}
oreq  output  cbus_req_t  request to the downstream bridge
oresp  input  cbus_resp_t  response from the downstream bridge

Behaviour:
- Reset values:
  - state=IDLE, sel=0, rr_ptr=0.
  - oreq is all-zero (valid=0).
  - Every iresps[i] is all-zero.
- State IDLE:
  - oreq is all-zero; all iresps are zero.
  - If any ireqs[i].valid=1, pick a winner, latch sel<=winner, go to BUSY next cycle.
  - Arbitration latency is exactly 1 cycle from valid to oreq.valid.
- Round-robin winner: the first i with ireqs[i].valid=1, scanning i=rr_ptr, rr_ptr+1, ... modulo NUM_MASTERS.
- State BUSY:
  - Combinational passthrough oreq=ireqs[sel] and iresps[sel]=oresp.
  - Non-selected iresps[j] stay all-zero (ready=0, last=0, data=0).
- BUSY to IDLE on either condition:
  - the handshake oresp.ready=1 && oresp.last=1 with ireqs[sel].valid=1 (normal completion); or
  - ireqs[sel].valid=0 (master abort).
- On leaving BUSY, update rr_ptr<=(sel+1) mod NUM_MASTERS. The wrap from NUM_MASTERS-1 goes to 0.
- Back-to-back transactions: a completing master drops valid in the cycle after last. The arbiter is then in IDLE, so a re-raised or pending request is re-arbitrated. The minimum gap between transactions on oreq is 1 idle cycle.
- Simultaneous requests: exactly one winner per the rule above. Losers keep valid asserted and see ready=0 until granted.
- Request changes while BUSY: the grant does not move if a higher-priority master raises valid mid-transaction.
- Single-beat (FIXED) transactions: complete on the first cycle where ready&&last=1.
- INCR bursts: sel is held over all len+1 beats. The downstream bridge advances addresses internally and the arbiter does not touch oreq.addr.
- Synchronous reset asserted mid-burst: next cycle is IDLE, oreq.valid=0, all iresps zero, rr_ptr=0. The in-flight master's transaction is dropped with no last.
- sel is never outside 0..NUM_MASTERS-1.
- Assertions (simulation only):
  - oreq.valid implies state==BUSY.
  - At most one iresps[i].ready high per cycle.

Optional Feature:
CBUS_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins. The winner is the lowest i with ireqs[i].valid=1; rr_ptr is not implemented and stays 0.
- Undefined (default): round-robin as described above.
- All other timing is identical in both builds.

Test Plan:
- Reset, then only master 1 asserts a FIXED read of addr 0x80000000 -> cycle+1: oreq.valid=1, oreq.addr=0x80000000. iresps[1] mirrors oresp (ready=1, last=1, data from bridge). iresps[0].ready=0. Back to IDLE, rr_ptr=0.
- Masters 0 and 1 both request continuously from reset -> grants alternate 0,1,0,1 across 4 transactions. With CBUS_ARB_FIXED_PRIO_EN, all 4 go to master 0 while it keeps requesting.
- Master 0 INCR burst len=3 at 0x80001000, master 1 raises valid on beat 1 -> sel stays 0 for all 4 beats. Master 1 sees ready=0 throughout and is granted 1 cycle after master 0's last beat.
- Reset asserted on beat 2 of a len=7 burst -> next cycle oreq.valid=0, all iresps zero. The first request after reset is arbitrated from rr_ptr=0.
- Master 0 drops valid mid-burst (beat 1 of len=3) -> next cycle state=IDLE, oreq.valid=0, rr_ptr=1. A pending master-1 request is granted on the following cycle.
- NUM_MASTERS=3, only master 2 requests repeatedly -> each grant after IDLE goes to 2. rr_ptr wraps 2->0 after each completion.
